// File: rtl/bioz_sweep_sequencer.sv
// bioz_sweep_sequencer: programmable BioZ Fsel sweep with AFE reset sequencing and ADC handshake
//   Clk, Reset (sync, active-high)         clock and reset
//   Start, Abort                            run request / immediate stop (Abort wins)
//   Dir, Fsel_Start, Fsel_Stop              sweep direction and code range
//   Dwell_Cycles, Num_Sweeps                per-step hold (0 acts as 1), sweep count (0 = continuous)
//   ADC_Done                                conversion complete pulse
//   Fsel, StepNum                           frequency code and per-step toggle to SigGen
//   Resetn, Clk_En, ADC_En, ADC_Start       AFE/ADC controls
//   Busy, Sweep_Done, Sweep_Count           run status
//   Timeout_Err                             sticky ADC timeout flag
// Optional: define SWEEP_ADC_TIMEOUT_EN to bound the ADC_Done wait to TIMEOUT_CYC cycles.
module bioz_sweep_sequencer #(
    parameter int FSEL_W      = 4,
    parameter int DWELL_W     = 24,
    parameter int NSWP_W      = 8,
    parameter int RST_PULSE   = 20,
    parameter int SETTLE_CYC  = 40,
    parameter int TIMEOUT_CYC = 1024
) (
    input  logic               Clk,
    input  logic               Reset,
    input  logic               Start,
    input  logic               Abort,
    input  logic               Dir,
    input  logic [FSEL_W-1:0]  Fsel_Start,
    input  logic [FSEL_W-1:0]  Fsel_Stop,
    input  logic [DWELL_W-1:0] Dwell_Cycles,
    input  logic [NSWP_W-1:0]  Num_Sweeps,
    input  logic               ADC_Done,
    output logic [FSEL_W-1:0]  Fsel,
    output logic               StepNum,
    output logic               Resetn,
    output logic               Clk_En,
    output logic               ADC_En,
    output logic               ADC_Start,
    output logic               Busy,
    output logic               Sweep_Done,
    output logic [NSWP_W-1:0]  Sweep_Count,
    output logic               Timeout_Err
);
    localparam int LIM   = RST_PULSE > SETTLE_CYC ? (RST_PULSE > TIMEOUT_CYC ? RST_PULSE : TIMEOUT_CYC)
                                                  : (SETTLE_CYC > TIMEOUT_CYC ? SETTLE_CYC : TIMEOUT_CYC);
    localparam int LIM_W = $clog2(LIM + 1);
    localparam int CNT_W = (DWELL_W > LIM_W ? DWELL_W : LIM_W) + 1;
    typedef enum logic [2:0] {IDLE, AFE_RST, SETTLE, DWELL, ACQ, DONE} state_t;
    state_t state, state_n;
    logic [CNT_W-1:0] cnt, cnt_n, dwell_eff;
    logic [FSEL_W-1:0] fsel_n, start_q, start_n, stop_q, stop_n;
    logic [DWELL_W-1:0] dwell_q, dwell_n;
    logic [NSWP_W-1:0] nswp_q, nswp_n, count_n, count_inc;
    logic dir_q, dir_n, step_n, afe_on, afe_on_n, adc_start_n, busy_n, sweep_done_n, terr_n;
    logic go, got, tmo, more, short_dwell;
    assign dwell_eff   = (dwell_q == '0) ? CNT_W'(1) : CNT_W'(dwell_q);
    assign short_dwell = dwell_eff == CNT_W'(1);
    assign count_inc   = &Sweep_Count ? Sweep_Count : Sweep_Count + NSWP_W'(1);
    assign more        = (nswp_q == '0) || (count_inc < nswp_q);
    assign go          = Start && !Abort && (state == IDLE || state == DONE);
`ifdef SWEEP_ADC_TIMEOUT_EN
    assign tmo = (state == ACQ) && !ADC_Done && (cnt == CNT_W'(TIMEOUT_CYC - 1));
`else
    assign tmo = 1'b0;
`endif
    assign got    = ADC_Done || tmo;
    assign Resetn = afe_on;
    assign Clk_En = afe_on;
    assign ADC_En = afe_on;
    // ADC_Start is looked ahead one cycle so it is high during the last dwell cycle itself.
    always_comb begin
        state_n      = state;
        cnt_n        = cnt + CNT_W'(1);
        fsel_n       = Fsel;
        step_n       = StepNum;
        count_n      = Sweep_Count;
        terr_n       = Timeout_Err;
        adc_start_n  = 1'b0;
        sweep_done_n = 1'b0;
        dir_n        = dir_q;
        start_n      = start_q;
        stop_n       = stop_q;
        dwell_n      = dwell_q;
        nswp_n       = nswp_q;
        if (Abort && state != IDLE) begin
            state_n = IDLE;
        end else if (go) begin
            dir_n   = Dir;
            start_n = Fsel_Start;
            stop_n  = Fsel_Stop;
            dwell_n = Dwell_Cycles;
            nswp_n  = Num_Sweeps;
            fsel_n  = Fsel_Start;
            count_n = '0;
            terr_n  = 1'b0;
            cnt_n   = '0;
            state_n = AFE_RST;
        end else begin
            case (state)
                AFE_RST: if (cnt == CNT_W'(RST_PULSE - 1)) begin
                    state_n = SETTLE;
                    cnt_n   = '0;
                end
                SETTLE: if (cnt == CNT_W'(SETTLE_CYC - 1)) begin
                    state_n     = DWELL;
                    cnt_n       = '0;
                    adc_start_n = short_dwell;
                end
                DWELL: if (cnt + CNT_W'(1) == dwell_eff) begin
                    state_n = ACQ;
                    cnt_n   = '0;
                end else begin
                    adc_start_n = cnt + CNT_W'(2) == dwell_eff;
                end
                ACQ: if (got) begin
                    terr_n = Timeout_Err | tmo;
                    cnt_n  = '0;
                    if (Fsel != stop_q) begin
                        fsel_n      = dir_q ? Fsel + FSEL_W'(1) : Fsel - FSEL_W'(1);
                        step_n      = !StepNum;
                        state_n     = DWELL;
                        adc_start_n = short_dwell;
                    end else begin
                        count_n = count_inc;
                        if (more) begin
                            fsel_n      = start_q;
                            step_n      = !StepNum;
                            state_n     = DWELL;
                            adc_start_n = short_dwell;
                        end else begin
                            sweep_done_n = 1'b1;
                            state_n      = DONE;
                        end
                    end
                end
                default: ;
            endcase
        end
        busy_n   = !(state_n == IDLE || state_n == DONE);
        afe_on_n = state_n inside {SETTLE, DWELL, ACQ, DONE};
    end
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state       <= IDLE;
            cnt         <= '0;
            Fsel        <= '0;
            StepNum     <= 1'b0;
            afe_on      <= 1'b0;
            ADC_Start   <= 1'b0;
            Busy        <= 1'b0;
            Sweep_Done  <= 1'b0;
            Sweep_Count <= '0;
            Timeout_Err <= 1'b0;
            dir_q       <= 1'b0;
            start_q     <= '0;
            stop_q      <= '0;
            dwell_q     <= '0;
            nswp_q      <= '0;
        end else begin
            state       <= state_n;
            cnt         <= cnt_n;
            Fsel        <= fsel_n;
            StepNum     <= step_n;
            afe_on      <= afe_on_n;
            ADC_Start   <= adc_start_n;
            Busy        <= busy_n;
            Sweep_Done  <= sweep_done_n;
            Sweep_Count <= count_n;
            Timeout_Err <= terr_n;
            dir_q       <= dir_n;
            start_q     <= start_n;
            stop_q      <= stop_n;
            dwell_q     <= dwell_n;
            nswp_q      <= nswp_n;
        end
    end
endmodule

// File: tb/tb_bioz_sweep_sequencer.sv
// tb_bioz_sweep_sequencer: directed scoreboard bench for bioz_sweep_sequencer
module tb_bioz_sweep_sequencer;
  logic clk = 0, rst = 1, start = 0, abort = 0, dir = 0;
  logic [3:0] fs = 0, fe = 0;
  logic [23:0] dwell = 0;
  logic [7:0] nswp = 0;
  logic done_auto = 0, done_man = 0;
  logic adc_done;
  logic [3:0] fsel;
  logic stepnum, resetn, clk_en, adc_en, adc_start, busy, sweep_done, timeout_err;
  logic [7:0] sweep_count;
  int n_checks = 0, n_err = 0;
  int exp_q[$];
  int n_starts = 0, n_tog = 0, n_sd = 0, cyc = 0, last = 0, gap = 0, dly = 0;
  logic prev_step = 0;
  bit auto_done = 1;
  int b_st, b_tog, b_sd, n, e;
  assign adc_done = done_auto | done_man;
  bioz_sweep_sequencer dut (
    .Clk(clk), .Reset(rst), .Start(start), .Abort(abort), .Dir(dir),
    .Fsel_Start(fs), .Fsel_Stop(fe), .Dwell_Cycles(dwell), .Num_Sweeps(nswp),
    .ADC_Done(adc_done), .Fsel(fsel), .StepNum(stepnum), .Resetn(resetn),
    .Clk_En(clk_en), .ADC_En(adc_en), .ADC_Start(adc_start), .Busy(busy),
    .Sweep_Done(sweep_done), .Sweep_Count(sweep_count), .Timeout_Err(timeout_err)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_err++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask
  always @(posedge clk) begin
    #1;
    cyc++;
    done_auto = 0;
    if (dly > 0) begin
      dly--;
      if (dly == 0) done_auto = 1;
    end
    if (rst) dly = 0;
    if (adc_start) begin
      n_starts++;
      gap = cyc - last;
      last = cyc;
      chk("sb_nonempty", exp_q.size() != 0, 1'b1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk("fsel_at_start", fsel, e[3:0]);
      end
      if (auto_done) dly = 5;
    end
    if (stepnum !== prev_step) n_tog++;
    prev_step = stepnum;
    if (sweep_done) n_sd++;
  end
  task automatic step();
    @(posedge clk);
    #2;
  endtask
  task automatic go();
    start = 1;
    step();
    start = 0;
  endtask
  task automatic snap();
    b_st = n_starts;
    b_tog = n_tog;
    b_sd = n_sd;
  endtask
  task automatic wait_idle(input int lim);
    int k = 0;
    while (busy && k < lim) begin
      step();
      k++;
    end
    chk("idle_wait", busy, 1'b0);
  endtask
  task automatic wait_starts(input int target, input int lim);
    int k = 0;
    while (n_starts < target && k < lim) begin
      step();
      k++;
    end
    chk("start_wait", n_starts >= target, 1'b1);
  endtask
  initial begin
    repeat (3) step();
    chk("reset_outputs", {fsel, stepnum, resetn, clk_en, adc_en, adc_start, busy, sweep_done, sweep_count, timeout_err}, 0);
    rst = 0;
    step();
    dir = 0; fs = 10; fe = 0; dwell = 100; nswp = 1;
    for (int i = 10; i >= 0; i--) exp_q.push_back(i);
    snap();
    go();
    chk("t1_busy", busy, 1'b1);
    n = 0;
    while (!resetn && n < 100) begin
      n++;
      step();
    end
    chk("t1_resetn_low", n, 20);
    chk("t1_clk_en", {clk_en, adc_en}, 2'b11);
    wait_idle(3000);
    chk("t1_starts", n_starts - b_st, 11);
    chk("t1_toggles", n_tog - b_tog, 10);
    chk("t1_sweep_done", n_sd - b_sd, 1);
    chk("t1_count", sweep_count, 8'd1);
    chk("t1_fsel", fsel, 4'd0);
    chk("t1_gap", gap, 105);
    chk("t1_done_afe", {resetn, clk_en, adc_en}, 3'b111);
    chk("t1_queue", exp_q.size(), 0);
    dir = 0; fs = 1; fe = 14; dwell = 3; nswp = 1;
    exp_q.push_back(1); exp_q.push_back(0); exp_q.push_back(15); exp_q.push_back(14);
    snap();
    go();
    wait_idle(500);
    chk("t2_starts", n_starts - b_st, 4);
    chk("t2_sweep_done", n_sd - b_sd, 1);
    chk("t2_count", sweep_count, 8'd1);
    chk("t2_fsel", fsel, 4'd14);
    chk("t2_queue", exp_q.size(), 0);
    dir = 1; fs = 3; fe = 5; dwell = 4; nswp = 0;
    for (int i = 0; i < 4; i++) begin
      exp_q.push_back(3); exp_q.push_back(4); exp_q.push_back(5);
    end
    snap();
    go();
    n = 0;
    while (sweep_count != 8'd4 && n < 500) begin
      step();
      n++;
    end
    chk("t3_count_reached", sweep_count, 8'd4);
    abort = 1;
    step();
    abort = 0;
    chk("t3_abort_outs", {busy, clk_en, adc_en, resetn, adc_start}, 5'b0);
    chk("t3_fsel_hold", fsel, 4'd3);
    chk("t3_count_hold", sweep_count, 8'd4);
    chk("t3_no_sweep_done", n_sd - b_sd, 0);
    chk("t3_toggles", n_tog - b_tog, 12);
    chk("t3_queue", exp_q.size(), 0);
    dir = 0; fs = 7; fe = 7; dwell = 0; nswp = 2;
    exp_q.push_back(7); exp_q.push_back(7);
    snap();
    go();
    wait_idle(500);
    chk("t4_starts", n_starts - b_st, 2);
    chk("t4_gap", gap, 6);
    chk("t4_count", sweep_count, 8'd2);
    chk("t4_fsel", fsel, 4'd7);
    chk("t4_toggles", n_tog - b_tog, 1);
    chk("t4_sweep_done", n_sd - b_sd, 1);
    abort = 1;
    step();
    abort = 0;
    chk("t5_done_abort", {busy, resetn, clk_en}, 3'b0);
    chk("t5_count_hold", sweep_count, 8'd2);
    fs = 2; fe = 3; dir = 1; dwell = 10; nswp = 1;
    start = 1; abort = 1;
    step();
    start = 0; abort = 0;
    chk("t5_start_abort_busy", busy, 1'b0);
    chk("t5_start_abort_fsel", fsel, 4'd7);
    exp_q.push_back(2); exp_q.push_back(3);
    snap();
    go();
    fs = 9; fe = 9; dwell = 50; nswp = 5;
    wait_starts(b_st + 1, 200);
    repeat (7) step();
    start = 1; done_man = 1;
    step();
    start = 0; done_man = 0;
    wait_idle(500);
    chk("t5_gap", gap, 15);
    chk("t5_starts", n_starts - b_st, 2);
    chk("t5_fsel", fsel, 4'd3);
    chk("t5_count", sweep_count, 8'd1);
    chk("t5_sweep_done", n_sd - b_sd, 1);
    chk("t5_queue", exp_q.size(), 0);
    auto_done = 0;
    dir = 1; fs = 4; fe = 5; dwell = 2; nswp = 1;
    exp_q.push_back(4);
`ifdef SWEEP_ADC_TIMEOUT_EN
    exp_q.push_back(5);
`endif
    snap();
    go();
    wait_starts(b_st + 1, 200);
`ifdef SWEEP_ADC_TIMEOUT_EN
    n = 0;
    while (!timeout_err && n < 2000) begin
      step();
      n++;
    end
    chk("t6_timeout_cycles", n, 1025);
    chk("t6_fsel_adv", fsel, 4'd5);
    chk("t6_busy", busy, 1'b1);
    wait_starts(b_st + 2, 100);
    repeat (3) step();
    chk("t6_err_sticky", timeout_err, 1'b1);
`else
    repeat (30) step();
    chk("t6_no_timeout", timeout_err, 1'b0);
    chk("t6_busy", busy, 1'b1);
    chk("t6_fsel", fsel, 4'd4);
`endif
    rst = 1;
    step();
    rst = 0;
    chk("t6_reset_outputs", {fsel, stepnum, resetn, clk_en, adc_en, adc_start, busy, sweep_done, sweep_count, timeout_err}, 0);
    chk("t6_queue", exp_q.size(), 0);
    step();
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end
endmodule
